// File: rtl/alu_div_pkg.sv
// Shared types and sign-correction helpers for the divider result path.
package alu_div_pkg;

    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] DIVZ_Q = '1;
    localparam int ENTRY_W = 2 * WIDTH + 1;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             err;
    } divEntry_t;

    // Two's-complement negation wraps, so the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] signFix(input logic [WIDTH-1:0] mag,
                                                 input logic             neg);
        logic [WIDTH-1:0] zero;
        zero = '0;
        return neg ? (zero - mag) : mag;
    endfunction

    function automatic divEntry_t buildEntry(input logic [WIDTH-1:0] rawQ,
                                             input logic [WIDTH-1:0] rawR,
                                             input logic             negQ,
                                             input logic             negR,
                                             input logic             divZero);
        divEntry_t e;
        e.q   = divZero ? DIVZ_Q : signFix(rawQ, negQ);
        e.r   = signFix(rawR, negR);
        e.err = divZero;
        return e;
    endfunction

endpackage

// File: rtl/div_result_fifo.sv
// Two-entry valid/ready FIFO; head data reads as zero while empty.
module div_result_fifo #(
    parameter int EntryW = 65
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrValid_i,
    output logic              wrReady_o,
    input  logic [EntryW-1:0] wrData_i,
    output logic              rdValid_o,
    input  logic              rdReady_i,
    output logic [EntryW-1:0] rdData_o
);

    logic [EntryW-1:0] mem_q [2];
    logic              wrPtr_q;
    logic              rdPtr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              push;
    logic              pop;

    // Ready depends only on stored occupancy, so a full FIFO refuses a push even while popping.
    assign wrReady_o = (count_q != 2'd2);
    assign rdValid_o = (count_q != 2'd0);
    assign push      = wrValid_i & wrReady_o;
    assign pop       = rdValid_o & rdReady_i;
    assign rdData_o  = rdValid_o ? mem_q[rdPtr_q] : '0;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wrPtr_q  <= 1'b0;
            rdPtr_q  <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= wrData_i;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/div_result_stage.sv
// Sign/divide-by-zero fixup ahead of a 2-entry result FIFO toward writeback.
// Defining DIV_ERR_CNT_EN adds err_count, a saturating count of popped error entries.
module div_result_stage
    import alu_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] raw_q,
    input  logic [WIDTH-1:0] raw_r,
    input  logic             neg_q,
    input  logic             neg_r,
    input  logic             div_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             err
`ifdef DIV_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    divEntry_t inEntry;
    divEntry_t headEntry;

    assign inEntry = buildEntry(raw_q, raw_r, neg_q, neg_r, div_zero);

    div_result_fifo #(
        .EntryW (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrValid_i (in_valid),
        .wrReady_o (in_ready),
        .wrData_i  (inEntry),
        .rdValid_o (out_valid),
        .rdReady_i (out_ready),
        .rdData_o  (headEntry)
    );

    assign q   = headEntry.q;
    assign r   = headEntry.r;
    assign err = headEntry.err;

`ifdef DIV_ERR_CNT_EN
    logic [7:0] errCount_q;
    logic [7:0] errCount_d;

    always_comb begin
        errCount_d = errCount_q;
        if (out_valid && out_ready && headEntry.err && (errCount_q != 8'hFF)) begin
            errCount_d = errCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCount_q <= 8'd0;
        end else begin
            errCount_q <= errCount_d;
        end
    end

    assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_div_result_stage.sv
// Self-checking bench for div_result_stage: vector table, hand sequences and a random run against a queue model.
module tb_div_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] raw_q;
    logic [31:0] raw_r;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic [31:0] r;
    logic        err;
`ifdef DIV_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int checks;
    int errors;

    div_result_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .raw_q     (raw_q),
        .raw_r     (raw_r),
        .neg_q     (neg_q),
        .neg_r     (neg_r),
        .div_zero  (div_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .err       (err)
`ifdef DIV_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rq;
        logic [31:0] rr;
        logic        nq;
        logic        nr;
        logic        dz;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
    } modelEntry_t;

    // Reference result computed as plain signed arithmetic modulo 2^32
    function automatic modelEntry_t refResult(input logic [31:0] rq, input logic [31:0] rr,
                                              input logic nq, input logic nr, input logic dz);
        modelEntry_t m;
        longint      mq;
        longint      mr;
        mq = nq ? -longint'(rq) : longint'(rq);
        mr = nr ? -longint'(rr) : longint'(rr);
        m.q   = dz ? 32'hFFFF_FFFF : mq[31:0];
        m.r   = mr[31:0];
        m.err = dz;
        return m;
    endfunction

    task automatic applyStimulus(input logic [31:0] rq, input logic [31:0] rr,
                                 input logic nq, input logic nr, input logic dz, input logic v);
        raw_q    = rq;
        raw_r    = rr;
        neg_q    = nq;
        neg_r    = nr;
        div_zero = dz;
        in_valid = v;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[8];
    modelEntry_t model[$];
    modelEntry_t a;
    modelEntry_t b;
    int          modelErrCount;
    logic        doPush;
    logic        doPop;
    int          tableErrs;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        out_ready = 1'b0;
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        vecs[0] = '{32'd7,          32'd2, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0};
        vecs[1] = '{32'd0,          32'd5, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5,         1'b1};
        vecs[2] = '{32'h8000_0000,  32'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd0,         1'b0};
        vecs[3] = '{32'd0,          32'd0, 1'b1, 1'b1, 1'b0, 32'd0,         32'd0,         1'b0};
        vecs[4] = '{32'd100,        32'd3, 1'b0, 1'b1, 1'b0, 32'd100,       32'hFFFF_FFFD, 1'b0};
        vecs[5] = '{32'd123,        32'd9, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd9,         1'b1};
        vecs[6] = '{32'd1,          32'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  32'd7, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd7,         1'b0};

        repeat (3) stepCycle();
        rst_n = 1'b1;
        stepCycle();

        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("reset_q",         q,                  32'd0);
        checkOutput("reset_r",         r,                  32'd0);
        checkOutput("reset_err",       {31'd0, err},       32'd0);

        // Table: push one entry, check the head next cycle, then let it pop
        out_ready = 1'b1;
        tableErrs = 0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rq, vecs[i].rr, vecs[i].nq, vecs[i].nr, vecs[i].dz, 1'b1);
            stepCycle();
            in_valid = 1'b0;
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("vec%0d_q", i),     q,                  vecs[i].eq);
            checkOutput($sformatf("vec%0d_r", i),     r,                  vecs[i].er);
            checkOutput($sformatf("vec%0d_err", i),   {31'd0, err},       {31'd0, vecs[i].ee});
            if (vecs[i].ee) tableErrs++;
            stepCycle();
            checkOutput($sformatf("vec%0d_empty", i), {31'd0, out_valid}, 32'd0);
            checkOutput($sformatf("vec%0d_q0", i),    q,                  32'd0);
        end
`ifdef DIV_ERR_CNT_EN
        checkOutput("table_err_count", {24'd0, err_count}, tableErrs);
`endif

        // Back-pressure: fill, refuse a third push, then drain in order
        out_ready = 1'b0;
        applyStimulus(32'd11, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
        applyStimulus(32'd22, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("bp_ready_after_b", {31'd0, in_ready}, 32'd0);
        applyStimulus(32'd33, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("bp_ready_full", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_head_held_a", q, 32'd11);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stepCycle();
        checkOutput("bp_head_b",        q,                  32'd22);
        checkOutput("bp_ready_pop1",    {31'd0, in_ready},  32'd1);
        checkOutput("bp_valid_b",       {31'd0, out_valid}, 32'd1);
        stepCycle();
        checkOutput("bp_drained",       {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop at count 1
        out_ready = 1'b0;
        applyStimulus(32'd44, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(32'd55, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        stepCycle();
        in_valid = 1'b0;
        checkOutput("pp_head_new",  q,                  32'd55);
        checkOutput("pp_valid",     {31'd0, out_valid}, 32'd1);
        checkOutput("pp_ready",     {31'd0, in_ready},  32'd1);
        stepCycle();
        checkOutput("pp_empty",     {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        applyStimulus(32'd66, 32'd6, 1'b0, 1'b0, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(32'd77, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        in_valid = 1'b0;
        checkOutput("ar_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("ar_q",     q,                  32'd0);
        checkOutput("ar_r",     r,                  32'd0);
        checkOutput("ar_err",   {31'd0, err},       32'd0);
        checkOutput("ar_ready", {31'd0, in_ready},  32'd1);
`ifdef DIV_ERR_CNT_EN
        checkOutput("ar_err_count", {24'd0, err_count}, 32'd0);
`endif
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        out_ready = 1'b1;
        stepCycle();
        checkOutput("ar_no_stale", {31'd0, out_valid}, 32'd0);

        // Random traffic against a queue model
        model.delete();
        modelErrCount = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            applyStimulus(($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                          ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 2) != 0);

            checkOutput("rnd_in_ready",  {31'd0, in_ready},  (model.size() < 2) ? 32'd1 : 32'd0);
            checkOutput("rnd_out_valid", {31'd0, out_valid}, (model.size() > 0) ? 32'd1 : 32'd0);
            if (model.size() > 0) begin
                a = model[0];
                checkOutput("rnd_q",   q,            a.q);
                checkOutput("rnd_r",   r,            a.r);
                checkOutput("rnd_err", {31'd0, err}, {31'd0, a.err});
            end else begin
                checkOutput("rnd_q_empty", q, 32'd0);
            end

            doPush = in_valid && (model.size() < 2);
            doPop  = out_ready && (model.size() > 0);
            if (doPop) begin
                b = model.pop_front();
                if (b.err && modelErrCount < 255) modelErrCount++;
            end
            if (doPush) model.push_back(refResult(raw_q, raw_r, neg_q, neg_r, div_zero));
            stepCycle();
        end
`ifdef DIV_ERR_CNT_EN
        checkOutput("rnd_err_count", {24'd0, err_count}, modelErrCount);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
